// File: rtl/sample_buffer_fifo_pkg.sv
// Shared constants and flag types for the FX3 sample buffer.
// No logic, so no latency.
// No flow control.
package sample_buffer_fifo_pkg;

    localparam int SAMPLE_WIDTH       = 16;
    localparam int FX3_BUS_WIDTH      = 16;
    localparam int DEFAULT_ADDR_WIDTH = 13;
    localparam int DEFAULT_AE_LEVEL   = 16;
    localparam int DROP_WIDTH         = 16;

    // Occupancy flags that gate the FX3 transfer state machine.
    typedef struct packed {
        logic almost_empty;
        logic half_full;
        logic full;
    } fifo_flags_t;

    // Decode the three occupancy flags from a level value.
    function automatic fifo_flags_t decode_flags(input int lvl, input int depth, input int ae_level);
        fifo_flags_t f;
        f.almost_empty = (lvl <= ae_level);
        f.half_full    = (lvl >= depth / 2);
        f.full         = (lvl == depth);
        return f;
    endfunction

endpackage

// File: rtl/sample_buffer_fifo_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Latency: write visible to a read on the next edge; read data 1 cycle after re.
// No backpressure; rdata holds whenever re is low.
module sample_buffer_fifo_dpram
    import sample_buffer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Write port: storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: the read register doubles as the FIFO output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_buffer_fifo.sv
// Single-clock first-word-fall-through sample FIFO feeding the FX3 GPIF data bus.
// Latency: 2 cycles push-to-visible when empty; back-to-back pops stream 1 word/cycle.
// Push while full without a pop is dropped and counted; pop while empty sets underrun.
module sample_buffer_fifo
    import sample_buffer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AE_LEVEL   = DEFAULT_AE_LEVEL
) (
    input  logic                  fx3_clock,
    input  logic                  fx3_reset,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  sample_valid,
    input  logic                  fx3_nWrite,
    input  logic                  clear_status,
    output logic [DATA_WIDTH-1:0] fx3_data,
    output logic                  fifoAlmostEmpty,
    output logic                  fifoHalfFull,
    output logic                  fifoFull,
    output logic [ADDR_WIDTH:0]   fifoLevel,
    output logic                  overflow,
    output logic                  underrun,
    output logic [DROP_WIDTH-1:0] dropCount
);

    localparam int                DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   level_next;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [ADDR_WIDTH:0]   ram_avail;
    logic                  out_valid;
    logic                  pop_req;
    logic                  pop;
    logic                  push;
    logic                  pop_out;
    logic                  pop_ram;
    logic                  load;
    logic                  ovf_evt;
    logic                  unr_evt;
    fifo_flags_t           flags_next;

    // Level counts every stored word: those still in RAM plus the one in the output register.
    // A pop before the output register has been filled consumes the RAM head directly.
    always_comb begin
        pop_req   = !fx3_nWrite;
        pop       = pop_req && (fifoLevel != '0);
        push      = sample_valid && ((fifoLevel != DEPTH_L) || pop);
        pop_out   = pop && out_valid;
        pop_ram   = pop && !out_valid;
        ram_cnt   = fifoLevel - {{ADDR_WIDTH{1'b0}}, out_valid};
        ram_avail = ram_cnt - {{ADDR_WIDTH{1'b0}}, pop_ram};
        load      = (!out_valid || pop_out) && (ram_avail != '0);
        rd_addr   = rd_ptr + ADDR_WIDTH'(pop_ram);
        ovf_evt   = sample_valid && !push;
        unr_evt   = pop_req && (fifoLevel == '0);
        level_next = fifoLevel;
        unique case ({push, pop})
            2'b10:   level_next = fifoLevel + 1'b1;
            2'b01:   level_next = fifoLevel - 1'b1;
            default: level_next = fifoLevel;
        endcase
        flags_next = decode_flags(int'(level_next), DEPTH, AE_LEVEL);
    end

    // Pointers, level, output-register valid and flags all advance on the same edge.
    always_ff @(posedge fx3_clock or posedge fx3_reset) begin
        if (fx3_reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifoLevel       <= '0;
            out_valid       <= 1'b0;
            fifoAlmostEmpty <= 1'b1;
            fifoHalfFull    <= 1'b0;
            fifoFull        <= 1'b0;
        end else begin
            wr_ptr          <= wr_ptr + ADDR_WIDTH'(push);
            rd_ptr          <= rd_ptr + ADDR_WIDTH'(pop_ram) + ADDR_WIDTH'(load);
            fifoLevel       <= level_next;
            out_valid       <= load || (out_valid && !pop_out);
            fifoAlmostEmpty <= flags_next.almost_empty;
            fifoHalfFull    <= flags_next.half_full;
            fifoFull        <= flags_next.full;
        end
    end

    // Sticky diagnostics; a clear in the same cycle as an event wins.
    always_ff @(posedge fx3_clock or posedge fx3_reset) begin
        if (fx3_reset) begin
            overflow  <= 1'b0;
            underrun  <= 1'b0;
            dropCount <= '0;
        end else if (clear_status) begin
            overflow  <= 1'b0;
            underrun  <= 1'b0;
            dropCount <= '0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
                if (dropCount != {DROP_WIDTH{1'b1}}) begin
                    dropCount <= dropCount + 1'b1;
                end
            end
            if (unr_evt) begin
                underrun <= 1'b1;
            end
        end
    end

    sample_buffer_fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (fx3_clock),
        .rst   (fx3_reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (sample_data),
        .re    (load),
        .raddr (rd_addr),
        .rdata (fx3_data)
    );

endmodule
